// File: rtl/dspi_stream_sink_checker_if.sv
// rtl/dspi_stream_sink_checker_if.sv - DSPI forward data bus plus back instruction bus
interface dspi_stream_sink_checker_if #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_WIDTH             = 4,
  parameter int CHUNK_ID_WIDTH              = 5,
  parameter int CHANNEL_ID_WIDTH            = 10,
  parameter int STATE_WIDTH                 = 32,
  parameter int INSTRUCTION_WIDTH           = 2,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16
);
  // forward data bus (producer -> sink)
  logic [DATA_WIDTH-1:0]       data;
  logic [1:0]                  data_type;
  logic                        last;
  logic [STREAM_ID_WIDTH-1:0]  stream_id;
  logic [CHUNK_ID_WIDTH-1:0]   chunk_id;
  logic [CHANNEL_ID_WIDTH-1:0] channel_id;
  logic [STATE_WIDTH-1:0]      state;

  // back instruction bus (sink -> producer)
  logic [INSTRUCTION_WIDTH-1:0]           instr_type;
  logic [STREAM_ID_WIDTH-1:0]             instr_stream_id;
  logic [CHANNEL_ID_WIDTH-1:0]            instr_channel_id;
  logic [INSTRUCTION_PARAMETER_WIDTH-1:0] instr_parameter;

  modport master (
    output data, data_type, last, stream_id, chunk_id, channel_id, state,
    input  instr_type, instr_stream_id, instr_channel_id, instr_parameter
  );

  modport slave (
    input  data, data_type, last, stream_id, chunk_id, channel_id, state,
    output instr_type, instr_stream_id, instr_channel_id, instr_parameter
  );
endinterface

// File: rtl/dspi_stream_sink_checker.sv
// rtl/dspi_stream_sink_checker.sv - credit-limited DSPI request issuer and chunk checker; DSPI_SINK_TIMEOUT_EN adds an idle watchdog
module dspi_stream_sink_checker #(
  parameter int DATA_WIDTH                  = 512,
  parameter int STREAM_ID_NUM               = 16,
  parameter int CHUNK_ID_NUM                = 32,
  parameter int CHANNEL_ID_NUM              = 1024,
  parameter int INSTRUCTION_WIDTH           = 2,
  parameter int INSTRUCTION_PARAMETER_WIDTH = 16,
  parameter int MAX_OUTSTANDING             = 4,
  parameter int BEATS_PER_CHUNK             = 8,
  parameter int TIMEOUT_CYCLES              = 4096,
  localparam int STREAM_ID_WIDTH            = $clog2(STREAM_ID_NUM),
  localparam int CHANNEL_ID_WIDTH           = $clog2(CHANNEL_ID_NUM)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic [STREAM_ID_WIDTH-1:0]  cfgStreamID,
  input  logic [CHANNEL_ID_WIDTH-1:0] cfgChannelID,
  input  logic [15:0]                 cfgNumChunks,
  dspi_stream_sink_checker_if.slave   bus,
  output logic                        busy,
  output logic                        done,
  output logic [3:0]                  errFlags,
  output logic [15:0]                 chunksReceived
);
  localparam int CHUNK_ID_WIDTH = $clog2(CHUNK_ID_NUM);
  localparam int NUM_WORDS      = DATA_WIDTH / 32;
  localparam int BEAT_WIDTH     = (BEATS_PER_CHUNK > 1) ? $clog2(BEATS_PER_CHUNK) : 1;
  localparam int PW             = INSTRUCTION_PARAMETER_WIDTH;

  localparam logic [INSTRUCTION_WIDTH-1:0] CMD_IDLE    = INSTRUCTION_WIDTH'(0);
  localparam logic [INSTRUCTION_WIDTH-1:0] CMD_REQUEST = INSTRUCTION_WIDTH'(1);
  localparam logic [INSTRUCTION_WIDTH-1:0] CMD_RESET   = INSTRUCTION_WIDTH'(3);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_ISSUE, S_DONE} state_t;

  state_t                      state;
  logic [STREAM_ID_WIDTH-1:0]  cfg_stream;
  logic [CHANNEL_ID_WIDTH-1:0] cfg_channel;
  logic [15:0]                 num_chunks;
  logic [15:0]                 requested;
  logic [15:0]                 outstanding;
  logic [BEAT_WIDTH-1:0]       beat;
  logic [CHUNK_ID_WIDTH-1:0]   exp_chunk;
  logic [15:0]                 seq;

  logic [INSTRUCTION_WIDTH-1:0] instr_type;
  logic [STREAM_ID_WIDTH-1:0]   instr_stream;
  logic [CHANNEL_ID_WIDTH-1:0]  instr_channel;
  logic [PW-1:0]                instr_param;

  logic                      accept;
  logic                      last_beat;
  logic                      close;
  logic                      issue;
  logic                      payload_ok;
  logic                      timeout_hit;
  logic [15:0]               room;
  logic [15:0]               remaining;
  logic [15:0]               grant;
  logic [CHUNK_ID_WIDTH-1:0] next_chunk;

  assign bus.instr_type       = instr_type;
  assign bus.instr_stream_id  = instr_stream;
  assign bus.instr_channel_id = instr_channel;
  assign bus.instr_parameter  = instr_param;

  assign accept     = busy && (bus.data_type == 2'd1) &&
                      (bus.stream_id == cfg_stream) && (bus.channel_id == cfg_channel);
  assign last_beat  = (beat == BEAT_WIDTH'(BEATS_PER_CHUNK - 1));
  assign close      = accept && (bus.last || last_beat);
  assign room       = 16'(MAX_OUTSTANDING) - outstanding;
  assign remaining  = num_chunks - requested;
  assign grant      = (room < remaining) ? room : remaining;
  // Leaving the previous instruction pulse idle for a cycle keeps issues at most one per two cycles
  assign issue      = (state == S_ISSUE) && (instr_type == CMD_IDLE) &&
                      (requested < num_chunks) && (outstanding < 16'(MAX_OUTSTANDING));
  assign next_chunk = (exp_chunk == CHUNK_ID_WIDTH'(CHUNK_ID_NUM - 1)) ? '0 : exp_chunk + 1'b1;

  // Each 32-bit word k must carry {run beat sequence, k}
  always_comb begin
    payload_ok = 1'b1;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (bus.data[32*k +: 32] != {seq, 16'(k)}) payload_ok = 1'b0;
    end
  end

`ifdef DSPI_SINK_TIMEOUT_EN
  logic [31:0] idle_cnt;

  // Idle watchdog: restarts on any accepted beat or issue, advances only while credit is out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (accept || issue || !busy) begin
      idle_cnt <= '0;
    end else if (outstanding != '0) begin
      idle_cnt <= idle_cnt + 32'd1;
    end
  end

  assign timeout_hit = busy && (outstanding != '0) && !accept && !issue &&
                       (idle_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // Run FSM, credit bookkeeping, beat checks and registered instruction bus
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= S_IDLE;
      cfg_stream     <= '0;
      cfg_channel    <= '0;
      num_chunks     <= '0;
      requested      <= '0;
      outstanding    <= '0;
      beat           <= '0;
      exp_chunk      <= '0;
      seq            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      errFlags       <= '0;
      chunksReceived <= '0;
      instr_type     <= CMD_IDLE;
      instr_stream   <= '0;
      instr_channel  <= '0;
      instr_param    <= '0;
    end else begin
      // instructions are single-cycle pulses; fields return to 0 between them
      instr_type    <= CMD_IDLE;
      instr_stream  <= '0;
      instr_channel <= '0;
      instr_param   <= '0;

      if (accept) begin
        seq <= seq + 16'd1;
        if (bus.chunk_id != exp_chunk) errFlags[0] <= 1'b1;
        if (!payload_ok)               errFlags[2] <= 1'b1;
        if (bus.last != last_beat)     errFlags[1] <= 1'b1;
        if (close) begin
          beat           <= '0;
          exp_chunk      <= next_chunk;
          chunksReceived <= chunksReceived + 16'd1;
          if (outstanding == '0) errFlags[0] <= 1'b1;
        end else begin
          beat <= beat + BEAT_WIDTH'(1);
        end
      end

      // a close landing on an issue cycle nets to grant-1; a stray close never underflows
      if (issue && close) begin
        outstanding <= outstanding + grant - 16'd1;
      end else if (issue) begin
        outstanding <= outstanding + grant;
      end else if (close && (outstanding != '0)) begin
        outstanding <= outstanding - 16'd1;
      end

      if (issue) begin
        requested     <= requested + grant;
        instr_type    <= CMD_REQUEST;
        instr_stream  <= cfg_stream;
        instr_channel <= cfg_channel;
        instr_param   <= PW'(grant);
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_RST;
            busy           <= 1'b1;
            done           <= 1'b0;
            errFlags       <= '0;
            chunksReceived <= '0;
            requested      <= '0;
            outstanding    <= '0;
            beat           <= '0;
            exp_chunk      <= '0;
            seq            <= '0;
            cfg_stream     <= cfgStreamID;
            cfg_channel    <= cfgChannelID;
            num_chunks     <= cfgNumChunks;
            instr_type     <= CMD_RESET;
            instr_stream   <= cfgStreamID;
            instr_channel  <= cfgChannelID;
          end
        end
        S_RST: begin
          if (num_chunks == '0) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if ((chunksReceived == num_chunks) && (outstanding == '0)) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (timeout_hit) begin
        errFlags[3] <= 1'b1;
        state       <= S_DONE;
        busy        <= 1'b0;
        done        <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dspi_stream_sink_checker.sv
// tb/tb_dspi_stream_sink_checker.sv - directed self-checking bench for dspi_stream_sink_checker
module tb_dspi_stream_sink_checker;
  localparam int DW = 512;
  localparam int NW = DW / 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  cfg_stream = 4'h5;
  logic [9:0]  cfg_channel = 10'h2A3;
  logic [15:0] cfg_num = 16'd0;
  logic        busy;
  logic        done;
  logic [3:0]  err;
  logic [15:0] chunks;

  int n_asserts = 0;
  int n_fail = 0;

  int corrupt_seq = -1;
  int corrupt_word = 0;
  int early_last = -1;
  int skip_id = -1;
  bit foreign_en = 1'b0;
  int req_total;
  int first_param;
  int max_credit;
  int wait_cnt;
  int t;
  int bad;

  dspi_stream_sink_checker_if #(.DATA_WIDTH(DW)) bus ();

  dspi_stream_sink_checker #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(100)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .start          (start),
    .cfgStreamID    (cfg_stream),
    .cfgChannelID   (cfg_channel),
    .cfgNumChunks   (cfg_num),
    .bus            (bus),
    .busy           (busy),
    .done           (done),
    .errFlags       (err),
    .chunksReceived (chunks)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_beat(input logic [1:0] typ, input logic [3:0] sid, input logic [4:0] cid,
                            input int sq, input logic lst, input int bad_word);
    logic [15:0] s16;
    logic [15:0] k16;
    s16 = 16'(sq);
    for (int k = 0; k < NW; k++) begin
      k16 = 16'(k);
      bus.data[32*k +: 32] = {s16, k16} ^ ((k == bad_word) ? 32'h0000_0100 : 32'h0);
    end
    bus.data_type  = typ;
    bus.stream_id  = sid;
    bus.chunk_id   = cid;
    bus.channel_id = cfg_channel;
    bus.last       = lst;
    bus.state      = $urandom;
  endtask

  task automatic idle_slot();
    drive_beat(2'd0, cfg_stream, 5'd31, int'($urandom_range(0, 65535)), 1'b1, 3);
  endtask

  task automatic run(input int num, input logic [3:0] exp_err);
    int credit = 0, chunk = 0, beat = 0, sq = 0, cyc = 0, gap_bad = 0, cid;
    bit fsent = 1'b0, prev_act = 1'b0, got_first = 1'b0;
    logic lst;
    req_total = 0; first_param = 0; max_credit = 0;
    cfg_num = 16'(num);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("reset_instr_type", bus.instr_type, 3);
    chk("reset_instr_param", bus.instr_parameter, 0);
    while (!done && cyc < 600) begin
      if (bus.instr_type != 2'd0 && prev_act) gap_bad++;
      prev_act = (bus.instr_type != 2'd0);
      if (bus.instr_type == 2'd1) begin
        if (!got_first) first_param = int'(bus.instr_parameter);
        got_first = 1'b1;
        credit += int'(bus.instr_parameter);
        req_total += int'(bus.instr_parameter);
        if (credit > max_credit) max_credit = credit;
      end
      if (credit > 0 && foreign_en && beat == 3 && !fsent) begin
        drive_beat(2'd1, cfg_stream + 4'd1, 5'd17, 999, 1'b1, -1);
        fsent = 1'b1;
      end else if (credit > 0) begin
        lst = (beat == 7) || (early_last == chunk && beat == 6);
        cid = (skip_id >= 0 && chunk >= skip_id) ? chunk + 1 : chunk;
        drive_beat(2'd1, cfg_stream, 5'(cid), sq, lst, (sq == corrupt_seq) ? corrupt_word : -1);
        sq++;
        if (lst) begin
          beat = 0; chunk++; credit--; fsent = 1'b0;
        end else begin
          beat++;
        end
      end else begin
        idle_slot();
      end
      @(negedge clk);
      cyc++;
    end
    idle_slot();
    chk("run_done", done, 1);
    chk("run_busy", busy, 0);
    chk("run_err", err, exp_err);
    chk("run_chunks", chunks, num);
    chk("run_requested", req_total, num);
    chk("run_first_param", first_param, (num < 4) ? num : 4);
    chk("run_max_outstanding", (max_credit <= 4), 1);
    chk("run_instr_gap", gap_bad, 0);
  endtask

  initial begin
    idle_slot();
    repeat (2) @(negedge clk);
    chk("rst_instr_type", bus.instr_type, 0);
    chk("rst_instr_fields", {bus.instr_stream_id, bus.instr_channel_id, bus.instr_parameter}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_chunks", chunks, 0);
    rstn = 1'b1;
    @(negedge clk);

    // ideal responder, single request of 3
    run(3, 4'b0000);
    // refill as chunks complete
    run(10, 4'b0000);
    // corrupt word 5 of the beat with seq 2
    corrupt_seq = 2; corrupt_word = 5;
    run(3, 4'b0100);
    corrupt_seq = -1;
    // early Last on beat 6 of chunk 0
    early_last = 0;
    run(2, 4'b0010);
    early_last = -1;
    // ChunkID 1 skipped, foreign stream beats interleaved
    skip_id = 1; foreign_en = 1'b1;
    run(2, 4'b0001);
    skip_id = -1; foreign_en = 1'b0;
    // zero-chunk run completes straight from reset instruction
    run(0, 4'b0000);

    // silent responder: one request, then stall
    cfg_num = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (bus.instr_type != 2'd1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("stall_req_type", bus.instr_type, 1);
    chk("stall_req_param", bus.instr_parameter, 4);
    chk("stall_req_ids", {bus.instr_stream_id, bus.instr_channel_id}, {4'h5, 10'h2A3});
    wait_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cnt++;
    chk("start_ignored_instr", bus.instr_type, 0);
    chk("start_ignored_busy", busy, 1);
`ifdef DSPI_SINK_TIMEOUT_EN
    while (!done && wait_cnt < 300) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("timeout_cycles", wait_cnt, 100);
    chk("timeout_done", done, 1);
    chk("timeout_err", err, 4'b1000);
`else
    repeat (200) @(negedge clk);
    chk("stall_busy", busy, 1);
    chk("stall_done", done, 0);
    chk("stall_err", err, 0);
`endif

    // asynchronous reset in the middle of a run
    if (!busy) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
    end
    chk("pre_reset_busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_instr_type", bus.instr_type, 0);
    chk("midrst_instr_param", bus.instr_parameter, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_chunks", chunks, 0);
    @(negedge clk);
    rstn = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.instr_type != 2'd0) bad++;
    end
    chk("no_instr_after_reset", bad, 0);

    // recovery from IDLE
    run(3, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
